// File: rtl/soc_bus_arbiter.sv
// Two-master round-robin arbiter for the SoC data bus. Each transaction is latched
// once and given per-region wait states. Unmapped addresses complete with an error.
module soc_bus_arbiter #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_a,
    input  logic        m0_we,
    input  logic [31:0] m0_wd,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic [31:0] m1_a,
    input  logic        m1_we,
    input  logic [31:0] m1_wd,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rd,
    output logic [31:0] bus_a,
    output logic        bus_we,
    output logic [31:0] bus_wd,
    input  logic [31:0] bus_rd
);

    localparam logic [3:0] MemWait = 4'(MEM_WAIT);
    localparam logic [3:0] IoWait  = 4'(IO_WAIT);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic        r_last;
    logic        r_gnt;
    logic        r_we;
    logic        r_unmapped;
    logic [31:0] r_a;
    logic [31:0] r_wd;
    logic [31:0] r_rd;

    logic        w_any_req;
    logic        w_win;
    logic [31:0] w_sel_a;
    logic        w_sel_we;
    logic [31:0] w_sel_wd;
    logic        w_is_mem;
    logic        w_is_io;
    logic [3:0]  w_wait_ld;
    logic        w_ack;

    // On a tie the master not served last wins; r_last resets to 1 so m0 wins first.
    always_comb begin
        w_any_req = m0_req | m1_req;
        w_win     = (m0_req && m1_req) ? ~r_last : m1_req;
        w_sel_a   = w_win ? m1_a  : m0_a;
        w_sel_we  = w_win ? m1_we : m0_we;
        w_sel_wd  = w_win ? m1_wd : m0_wd;
        w_is_mem  = (w_sel_a[31:8] == 24'h000000);
        w_is_io   = (w_sel_a[31:8] == 24'h000008) || (w_sel_a[31:8] == 24'h000009);
        w_wait_ld = w_is_mem ? MemWait : (w_is_io ? IoWait : 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= 4'd0;
            r_last     <= 1'b1;
            r_gnt      <= 1'b0;
            r_we       <= 1'b0;
            r_unmapped <= 1'b0;
            r_a        <= 32'h0;
            r_wd       <= 32'h0;
            r_rd       <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_gnt      <= w_win;
                        r_last     <= w_win;
                        r_a        <= w_sel_a;
                        r_we       <= w_sel_we;
                        r_wd       <= w_sel_wd;
                        r_unmapped <= ~(w_is_mem | w_is_io);
                        r_cnt      <= w_wait_ld;
                        r_state    <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rd    <= r_unmapped ? 32'h0 : bus_rd;
                        r_state <= StResp;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state, so reset clears them at once.
    always_comb begin
        w_ack  = (r_state == StResp);
        m0_ack = w_ack & ~r_gnt;
        m1_ack = w_ack &  r_gnt;
        m0_err = m0_ack & r_unmapped;
        m1_err = m1_ack & r_unmapped;
        m0_rd  = m0_ack ? r_rd : 32'h0;
        m1_rd  = m1_ack ? r_rd : 32'h0;
        bus_a  = r_a;
        bus_wd = r_wd;
        bus_we = (r_state == StWait) && (r_cnt == 4'd0) && r_we && !r_unmapped;
    end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed bench for soc_bus_arbiter (MEM_WAIT=0, IO_WAIT=2) with hand-computed
// cycle numbers; cycle 0 is the IDLE cycle in which the request is first seen.
module tb_soc_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_a, m0_wd, m0_rd;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_a, m1_wd, m1_rd;
    logic [31:0] bus_a, bus_wd, bus_rd;
    logic        bus_we;

    int n_chk = 0;
    int n_err = 0;

    soc_bus_arbiter #(
        .MEM_WAIT(0),
        .IO_WAIT (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0_req(m0_req),
        .m0_a  (m0_a),
        .m0_we (m0_we),
        .m0_wd (m0_wd),
        .m0_ack(m0_ack),
        .m0_err(m0_err),
        .m0_rd (m0_rd),
        .m1_req(m1_req),
        .m1_a  (m1_a),
        .m1_we (m1_we),
        .m1_wd (m1_wd),
        .m1_ack(m1_ack),
        .m1_err(m1_err),
        .m1_rd (m1_rd),
        .bus_a (bus_a),
        .bus_we(bus_we),
        .bus_wd(bus_wd),
        .bus_rd(bus_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_m(input int m, input logic req, input logic [31:0] a,
                           input logic we, input logic [31:0] wd);
        if (m == 0) begin
            m0_req = req; m0_a = a; m0_we = we; m0_wd = wd;
        end else begin
            m1_req = req; m1_a = a; m1_we = we; m1_wd = wd;
        end
    endtask

    // Called just after a rising edge with the DUT idle. Address/data are scrambled
    // after the grant to show the latched copy is what reaches the bus.
    task automatic run_txn(input int m, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, output int ack_cyc,
                           output logic [31:0] rd, output logic err, output int we_cnt,
                           output int we_cyc, output logic [31:0] we_a,
                           output logic [31:0] we_wd, output int stray);
        logic ack, oack;
        ack_cyc = -1; rd = 32'hx; err = 1'bx;
        we_cnt = 0; we_cyc = -1; we_a = 32'h0; we_wd = 32'h0; stray = 0;
        drive_m(m, 1'b1, a, we, wd);
        for (int c = 0; c < 40 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (bus_we) begin
                we_cnt++; we_cyc = c; we_a = bus_a; we_wd = bus_wd;
            end
            if (c == 1) drive_m(m, 1'b1, ~a, ~we, ~wd);
            ack  = (m == 0) ? m0_ack : m1_ack;
            oack = (m == 0) ? m1_ack : m0_ack;
            if (oack) stray++;
            if (ack) begin
                ack_cyc = c;
                rd  = (m == 0) ? m0_rd  : m1_rd;
                err = (m == 0) ? m0_err : m1_err;
            end
        end
        @(posedge clk); #1;
        drive_m(m, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_out"}, {29'h0, bus_we, m0_ack | m0_err, m1_ack | m1_err}, 32'h0);
        check_eq({tag, "_bus_a"},  bus_a,  32'h0);
        check_eq({tag, "_bus_wd"}, bus_wd, 32'h0);
        check_eq({tag, "_rd"},     m0_rd | m1_rd, 32'h0);
    endtask

    int          ack_cyc, we_cnt, we_cyc, stray, got_n, both_hi;
    logic [31:0] rd, we_a, we_wd;
    logic        err;
    int          order[4];

    initial begin
        rst_n = 1'b0;
        bus_rd = 32'h0;
        drive_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        check_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // m0 read from data memory, no wait states
        bus_rd = 32'hDEADBEEF;
        run_txn(0, 32'h0000_0010, 1'b0, 32'h0, ack_cyc, rd, err, we_cnt, we_cyc, we_a,
                we_wd, stray);
        check_eq("rd_ack_cyc", ack_cyc, 2);
        check_eq("rd_data",    rd,      32'hDEADBEEF);
        check_eq("rd_err",     {31'h0, err}, 0);
        check_eq("rd_we_cnt",  we_cnt,  0);
        check_eq("rd_stray",   stray,   0);

        // m1 GPIO write, two wait states
        run_txn(1, 32'h0000_0804, 1'b1, 32'h5A, ack_cyc, rd, err, we_cnt, we_cyc, we_a,
                we_wd, stray);
        check_eq("wr_we_cnt",  we_cnt,  1);
        check_eq("wr_we_cyc",  we_cyc,  3);
        check_eq("wr_bus_a",   we_a,    32'h0000_0804);
        check_eq("wr_bus_wd",  we_wd,   32'h5A);
        check_eq("wr_ack_cyc", ack_cyc, 4);
        check_eq("wr_err",     {31'h0, err}, 0);
        check_eq("wr_stray",   stray,   0);

        // unmapped write
        run_txn(0, 32'h0000_1000, 1'b1, 32'h77, ack_cyc, rd, err, we_cnt, we_cyc, we_a,
                we_wd, stray);
        check_eq("um_ack_cyc", ack_cyc, 2);
        check_eq("um_err",     {31'h0, err}, 1);
        check_eq("um_rd",      rd,      32'h0);
        check_eq("um_we_cnt",  we_cnt,  0);

        // contention from reset: both masters request continuously
        rst_n = 1'b0;
        drive_m(0, 1'b1, 32'h0000_0010, 1'b0, 32'h0);
        drive_m(1, 1'b1, 32'h0000_0900, 1'b0, 32'h0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        got_n = 0; both_hi = 0;
        for (int c = 0; c < 60 && got_n < 4; c++) begin
            @(negedge clk);
            if (m0_ack && m1_ack) both_hi++;
            if (m0_ack) begin order[got_n] = 0; got_n++; end
            else if (m1_ack) begin order[got_n] = 1; got_n++; end
        end
        @(posedge clk); #1;
        drive_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("ct_count", got_n, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("ct_grant%0d", i), (i < got_n) ? order[i] : -1, i % 2);
        end
        check_eq("ct_both_ack", both_hi, 0);
        @(posedge clk); #1;

        // reset during an IO_WAIT countdown (cycle 2: WAIT with cnt=1)
        drive_m(1, 1'b1, 32'h0000_0804, 1'b1, 32'hA5);
        @(negedge clk); @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        drive_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (m0_ack || m1_ack || bus_we) stray++;
        end
        check_eq("mid_rst_quiet", stray, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        bus_rd = 32'h1234_5678;
        run_txn(1, 32'h0000_0900, 1'b0, 32'h0, ack_cyc, rd, err, we_cnt, we_cyc, we_a,
                we_wd, stray);
        check_eq("post_ack_cyc", ack_cyc, 4);
        check_eq("post_rd",      rd,      32'h1234_5678);
        check_eq("post_stray",   stray,   0);

        // first tie afterwards goes to m0
        drive_m(0, 1'b1, 32'h0000_0010, 1'b0, 32'h0);
        drive_m(1, 1'b1, 32'h0000_0804, 1'b0, 32'h0);
        got_n = -1;
        for (int c = 0; c < 20 && got_n < 0; c++) begin
            @(negedge clk);
            if (m0_ack) got_n = 0;
            else if (m1_ack) got_n = 1;
        end
        check_eq("tie_after_rst", got_n, 0);
        @(posedge clk); #1;
        drive_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_m(1, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/soc_bus_arbiter.md
# soc_bus_arbiter

Arbitrates two bus masters onto the single SoC data bus: port 0 is the MIPS data-memory port, port 1 is the DMA/debug port. The address decoder and the data memory / GPIO peripherals sit downstream. The arbiter grants masters round-robin, latches one transaction at a time, and inserts per-region wait states. It drives a single-cycle write strobe and returns read data with a one-cycle acknowledge. It also flags accesses to unmapped addresses instead of letting them reach the decoder's don't-care default.

## Interface
- MEM_WAIT, 0, extra wait cycles for the data-memory region, a[31:8]==24'h000000 (0..15)
- IO_WAIT, 2, extra wait cycles for the GPIO regions, a[31:8]==24'h000008 or 24'h000009 (0..15)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  transaction request; held high until the matching ack
- m0_a, m1_a  in  32  byte address
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_wd, m1_wd  in  32  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  high with ack when the address was unmapped
- m0_rd, m1_rd  out  32  read data, valid while the matching ack is high
- bus_a  out  32  address to the decoder
- bus_we  out  1  write strobe to the decoder
- bus_wd  out  32  write data to the bus
- bus_rd  in  32  read data from the bus read mux

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - With no request pending, stay in IDLE.
  - On any request, pick a winner and latch its a/we/wd, the grant id and the region.
  - Load cnt with the region's wait count: MEM_WAIT, IO_WAIT, or 0 when unmapped.
  - Go to WAIT.
- Arbitration:
  - A single requester is granted.
  - When both request, grant the master not served last.
  - The `last` flag resets to 1, so m0 wins the first tie.
  - `last` updates on every grant.
- WAIT:
  - bus_a and bus_wd drive the latched values throughout.
  - If cnt != 0, decrement cnt and stay in WAIT.
  - If cnt == 0:
    - bus_we = latched we AND mapped, for this one cycle only.
    - The bus_rd sample is registered.
    - Go to RESP.
- RESP:
  - The granted master's ack is high for one cycle.
  - Its rd carries the registered sample; a write returns the sample, don't-care for the master.
  - Its err = unmapped.
  - Next state is IDLE.
- Unmapped access:
  - Only 1 WAIT cycle.
  - bus_we stays 0 and rd = 32'h0.
  - ack and err are high together.
- Outside WAIT: bus_we = 0, bus_a = latched address (unchanged), bus_wd = latched data.
- The ungranted master's ack, err and rd stay 0.
- cnt is 4 bits wide. Region decode uses only a[31:8]; a[32] does not exist (the address is 32 bits).

## Timing
- Reset values: state = IDLE, cnt = 0, last = 1, latched a/wd = 0, rd sample = 0.
- All outputs are 0 during reset.
- Reset asserted mid-transaction:
  - Aborts immediately; no ack is issued.
  - bus_we drops asynchronously.
  - The master must re-request after reset.
- Latency:
  - A request seen in IDLE at cycle 0 gives WAIT in cycles 1..W+1 and ack in cycle W+2, where W is the region wait (0 when unmapped).
  - The sustained rate is one transaction per W+3 cycles.
- Master handshake:
  - The master must drop or change req at the same edge that ends its ack cycle.
  - The arbiter re-samples requests in the IDLE cycle after RESP and never in RESP itself, so no double grant can occur.
- Requests are sampled only in IDLE. Changes to a/we/wd after the grant are ignored.
- Simultaneous requests: exactly one grant per IDLE. The loser keeps req high and is granted at the next IDLE.
- Exactly one bus_we pulse per write transaction.

## Test plan
- Reset then single request:
  - Stimulus: m0 read at 0x00000010, MEM_WAIT=0, bus_rd=0xDEADBEEF.
  - Required: m0_ack in cycle 2, m0_rd=0xDEADBEEF, m0_err=0, bus_we never high.
- GPIO write:
  - Stimulus: m1 write at 0x00000804, wd=0x5A, IO_WAIT=2.
  - Required: bus_we high exactly one cycle (cycle 3), with bus_a=0x804 and bus_wd=0x5A; m1_ack in cycle 4.
- Contention:
  - Stimulus: both masters request continuously from reset.
  - Required: grants alternate m0, m1, m0, m1; no cycle has both acks high.
- Unmapped address:
  - Stimulus: m0 write at 0x00001000.
  - Required: m0_ack=m0_err=1 in cycle 2, m0_rd=0, bus_we stays 0.
- Reset mid-WAIT:
  - Stimulus: rst_n pulled low during an IO_WAIT countdown.
  - Required: all outputs 0 immediately, no ack. After release, a fresh m1-only request is served normally; the first tie afterwards goes to m0.
